// File: rtl/keyentry.sv
// Decimal digit-entry: synchronise and debounce ten digit keys, shift presses into a
// 3-digit BCD entry, and convert the entry to binary with a sequential x10 accumulator.
module keyentry #(
    parameter int DEB_CNT = 50000,
    parameter int DEB_W   = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [9:0]  keys,
    input  logic        clr,
    output logic [11:0] bcd,
    output logic [1:0]  ndig,
    output logic [9:0]  bin,
    output logic        bin_valid,
    output logic        busy
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CNT - 1);

    localparam logic [0:0] P_IDLE = 1'b0;
    localparam logic [0:0] P_HELD = 1'b1;

    localparam logic [1:0] CIDLE = 2'd0;
    localparam logic [1:0] C2    = 2'd1;
    localparam logic [1:0] C1    = 2'd2;
    localparam logic [1:0] C0    = 2'd3;

    logic [9:0]       sync1, key_s, cand, key_db;
    logic [DEB_W-1:0] cnt, cnt_inc;
    logic [0:0]       pstate, pstate_d;
    logic [1:0]       cstate;
    logic [11:0]      snap, bcd_d;
    logic [1:0]       ndig_d;
    logic [9:0]       acc, acc_x10;
    logic             key_nz, onehot, strobe, start;
    logic [3:0]       digit;

    assign cnt_inc = cnt + DEB_W'(1);

    // Debounce works on the whole vector: any change restarts the stability count.
    always_ff @(posedge clk) begin
        if (RST) begin
            sync1  <= '0;
            key_s  <= '0;
            cand   <= '0;
            key_db <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= keys;
            key_s <= sync1;
            if (key_s != cand) begin
                cand <= key_s;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt_inc;
                if (cnt_inc == CNT_MAX) key_db <= cand;
            end
        end
    end

    always_comb begin
        key_nz = |key_db;
        onehot = key_nz && ((key_db & (key_db - 10'd1)) == 10'd0);
        digit  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_db[i]) digit = 4'(i);
        end
        strobe   = (pstate == P_IDLE) && onehot;
        pstate_d = pstate;
        if (pstate == P_IDLE && key_nz) pstate_d = P_HELD;
        else if (pstate == P_HELD && !key_nz) pstate_d = P_IDLE;
    end

    // clr takes priority over a coincident digit strobe.
    always_comb begin
        bcd_d  = bcd;
        ndig_d = ndig;
        if (clr) begin
            bcd_d  = 12'd0;
            ndig_d = 2'd0;
        end else if (strobe) begin
            bcd_d  = {bcd[7:0], digit};
            ndig_d = (ndig == 2'd3) ? 2'd3 : ndig + 2'd1;
        end
        start = clr | strobe;
    end

    assign acc_x10 = (acc << 3) + (acc << 1);
    assign busy    = (cstate != CIDLE);

    always_ff @(posedge clk) begin
        if (RST) begin
            pstate    <= P_IDLE;
            bcd       <= '0;
            ndig      <= '0;
            cstate    <= CIDLE;
            snap      <= '0;
            acc       <= '0;
            bin       <= '0;
            bin_valid <= 1'b0;
        end else begin
            pstate    <= pstate_d;
            bcd       <= bcd_d;
            ndig      <= ndig_d;
            bin_valid <= 1'b0;
            // A new start always wins, aborting any conversion in flight.
            if (start) begin
                snap   <= bcd_d;
                cstate <= C2;
            end else begin
                case (cstate)
                    C2: begin
                        acc    <= {6'd0, snap[11:8]};
                        cstate <= C1;
                    end
                    C1: begin
                        acc    <= acc_x10 + {6'd0, snap[7:4]};
                        cstate <= C0;
                    end
                    C0: begin
                        bin       <= acc_x10 + {6'd0, snap[3:0]};
                        bin_valid <= 1'b1;
                        cstate    <= CIDLE;
                    end
                    default: cstate <= CIDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keyentry.sv
// Scoreboard bench for keyentry: expected conversions are queued as keys are driven and
// popped by an independent monitor on every bin_valid strobe.
module tb_keyentry;

    logic        clk;
    logic        RST;
    logic [9:0]  keys;
    logic        clr;
    logic [11:0] bcd;
    logic [1:0]  ndig;
    logic [9:0]  bin;
    logic        bin_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int expq[$];

    logic [11:0] mbcd;
    logic [1:0]  mndig;

    keyentry #(.DEB_CNT(4), .DEB_W(16)) dut (
        .clk       (clk),
        .RST       (RST),
        .keys      (keys),
        .clr       (clr),
        .bcd       (bcd),
        .ndig      (ndig),
        .bin       (bin),
        .bin_valid (bin_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bin_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_bin_valid", 1, 0);
            end else begin
                check("bin_on_valid", int'(bin), expq.pop_front());
            end
        end
    end

    function automatic void model_digit(input int d);
        mbcd  = {mbcd[7:0], 4'(d)};
        mndig = (mndig == 2'd3) ? 2'd3 : mndig + 2'd1;
    endfunction

    function automatic void model_clear();
        mbcd  = 12'd0;
        mndig = 2'd0;
    endfunction

    task automatic press(input int d);
        model_digit(d);
        expq.push_back(bcd2int(mbcd));
        keys = 10'b1 << d;
        repeat (10) @(negedge clk);
        keys = 10'd0;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_entry(input string name);
        check({name, "_bcd"}, int'(bcd), int'(mbcd));
        check({name, "_ndig"}, int'(ndig), int'(mndig));
    endtask

    initial begin
        RST  = 1'b1;
        keys = 10'd0;
        clr  = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_bcd", int'(bcd), 0);
        check("rst_ndig", int'(ndig), 0);
        check("rst_bin", int'(bin), 0);
        check("rst_bin_valid", int'(bin_valid), 0);
        check("rst_busy", int'(busy), 0);
        RST = 1'b0;
        repeat (8) @(negedge clk);

        // Basic entry and overflow shift
        press(1);
        press(2);
        press(3);
        check_entry("basic");
        check("basic_bin", int'(bin), 123);
        press(9);
        check_entry("overflow");
        check("overflow_bin", int'(bin), 239);

        // Short glitch on key 5
        keys = 10'b1 << 5;
        repeat (2) @(negedge clk);
        keys = 10'd0;
        repeat (12) @(negedge clk);
        check_entry("glitch");

        // Chord of keys 3 and 4
        keys = (10'b1 << 3) | (10'b1 << 4);
        repeat (10) @(negedge clk);
        keys = 10'd0;
        repeat (10) @(negedge clk);
        check_entry("chord");

        // Press 7, add key 8 while held: one digit only
        model_digit(7);
        expq.push_back(bcd2int(mbcd));
        keys = 10'b1 << 7;
        repeat (10) @(negedge clk);
        keys = keys | (10'b1 << 8);
        repeat (10) @(negedge clk);
        keys = 10'd0;
        repeat (10) @(negedge clk);
        check_entry("held_add");

        press(9);
        press(9);
        press(9);
        check_entry("nines");
        check("nines_bin", int'(bin), 999);

        // Clear pulse with conversion timing
        clr = 1'b1;
        model_clear();
        expq.push_back(0);
        @(negedge clk);
        clr = 1'b0;
        check_entry("clr");
        check("clr_busy_c2", int'(busy), 1);
        check("clr_valid_c2", int'(bin_valid), 0);
        repeat (2) @(negedge clk);
        check("clr_busy_c0", int'(busy), 1);
        @(negedge clk);
        check("clr_valid_s3", int'(bin_valid), 1);
        check("clr_busy_s3", int'(busy), 0);
        @(negedge clk);
        check("clr_valid_drop", int'(bin_valid), 0);
        repeat (5) @(negedge clk);

        // clr coincident with the strobe edge of a digit-2 press
        keys = 10'b1 << 2;
        repeat (6) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        expq.push_back(0);
        repeat (3) @(negedge clk);
        keys = 10'd0;
        repeat (10) @(negedge clk);
        check_entry("clr_coincident");

        // clr during C1 of a digit-5 conversion
        keys = 10'b1 << 5;
        repeat (8) @(negedge clk);
        check("abort_busy_c1", int'(busy), 1);
        check("abort_bcd_pre", int'(bcd), 12'h005);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
        expq.push_back(0);
        repeat (9) @(negedge clk);
        keys = 10'd0;
        repeat (10) @(negedge clk);
        check_entry("abort_clr");

        // RST during C1 of a digit-6 conversion
        keys = 10'b1 << 6;
        repeat (8) @(negedge clk);
        RST  = 1'b1;
        keys = 10'd0;
        @(negedge clk);
        RST = 1'b0;
        model_clear();
        check("abort_rst_bcd", int'(bcd), 0);
        check("abort_rst_ndig", int'(ndig), 0);
        check("abort_rst_bin", int'(bin), 0);
        check("abort_rst_valid", int'(bin_valid), 0);
        check("abort_rst_busy", int'(busy), 0);
        repeat (20) @(negedge clk);
        check_entry("post_rst");
        check("post_rst_bin", int'(bin), 0);

        check("pending_expectations", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
